// File: rtl/pc_pkg.sv
// Shared types for the fetch-stage program counter: FSM states, redirect sources,
// and the target alignment mask.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } pc_state_t;

  typedef enum logic [2:0] {
    SRC_EXC  = 3'd0,
    SRC_JR   = 3'd1,
    SRC_BR   = 3'd2,
    SRC_J    = 3'd3,
    SRC_SEQ  = 3'd4,
    SRC_HOLD = 3'd5
  } pc_src_t;

  // Bits that must be zero in any redirect target for a given instruction size.
  function automatic int align_mask(input int inst_bytes);
    return inst_bytes - 1;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch-side bundle of the PC sequencer: redirect/halt controls in, fetch request out.
// master = sequencer, slave = pipeline control plus instruction memory.
interface pc_sequencer_if #(
  parameter int ADDR_W = 32
);
  logic              halt;
  logic              fetch_ready;
  logic              exception;
  logic              jr;
  logic [ADDR_W-1:0] jr_target;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic              jump;
  logic [ADDR_W-1:0] jump_target;
  logic              link;
  logic              ret;
  logic [ADDR_W-1:0] inst_address;
  logic [ADDR_W-1:0] pc_plus4;
  logic              fetch_valid;
  logic              misalign_err;

  modport master (
    input  halt, fetch_ready, exception, jr, jr_target, branch_taken, branch_target,
    input  jump, jump_target, link, ret,
    output inst_address, pc_plus4, fetch_valid, misalign_err
  );

  modport slave (
    output halt, fetch_ready, exception, jr, jr_target, branch_taken, branch_target,
    output jump, jump_target, link, ret,
    input  inst_address, pc_plus4, fetch_valid, misalign_err
  );

endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
// top/empty reflect registered state, so they are usable combinationally by the caller.
module pc_ras #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_data,
  input  logic              pop,
  output logic [ADDR_W-1:0] top,
  output logic              empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W:0]    count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr + 1'b1;
      if (count != FULL) begin
        count <= count + 1'b1;
      end
    end else if (pop) begin
      ptr   <= ptr - 1'b1;
      count <= count - 1'b1;
    end
  end

  // Entry storage carries no reset; the count alone defines what is live.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[ptr + 1'b1] <= push_data;
    end
  end

  assign top   = mem[ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with prioritised redirects, alignment check and halt control.
// Optional return-address stack is built when PC_RAS_EN is defined.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter logic [ADDR_W-1:0] EXC_VECTOR   = ADDR_W'('h80),
  parameter int                INST_BYTES   = 4,
  parameter int                RAS_DEPTH    = 4
) (
  input  logic           clock,
  input  logic           reset_n,
  pc_sequencer_if.master bus
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(align_mask(INST_BYTES));
  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(INST_BYTES);

  pc_state_t         state;
  logic [ADDR_W-1:0] pc_q;
  logic              fetch_valid_q;
  logic              misalign_q;

  pc_src_t           src;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] jr_dest;
  logic [ADDR_W-1:0] next_pc;
  logic [ADDR_W-1:0] pc_inc;
  logic              redirect;
  logic              misaligned;

  assign pc_inc = pc_q + STEP;

  always_comb begin
    src    = SRC_HOLD;
    target = pc_q;
    if (bus.exception) begin
      src    = SRC_EXC;
      target = EXC_VECTOR;
    end else if (bus.jr) begin
      src    = SRC_JR;
      target = jr_dest;
    end else if (bus.branch_taken) begin
      src    = SRC_BR;
      target = bus.branch_target;
    end else if (bus.jump) begin
      src    = SRC_J;
      target = bus.jump_target;
    end else if (fetch_valid_q && bus.fetch_ready) begin
      src    = SRC_SEQ;
      target = pc_inc;
    end
  end

  assign redirect   = (src != SRC_SEQ) && (src != SRC_HOLD);
  assign misaligned = redirect && (src != SRC_EXC) && ((target & ALIGN_MASK) != '0);
  assign next_pc    = misaligned ? EXC_VECTOR : target;

`ifdef PC_RAS_EN
  logic              ras_push;
  logic              ras_pop;
  logic              ras_empty;
  logic [ADDR_W-1:0] ras_top;

  assign jr_dest  = (bus.ret && !ras_empty) ? ras_top : bus.jr_target;
  // Only a call/return that actually redirects is allowed to move the stack.
  assign ras_push = (src == SRC_J) && bus.link && !misaligned;
  assign ras_pop  = (src == SRC_JR) && bus.ret && !ras_empty && !misaligned;

  pc_ras #(
    .ADDR_W (ADDR_W),
    .DEPTH  (RAS_DEPTH)
  ) u_ras (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (ras_push),
    .push_data (pc_inc),
    .pop       (ras_pop),
    .top       (ras_top),
    .empty     (ras_empty)
  );
`else
  logic unused_ras;

  assign jr_dest    = bus.jr_target;
  assign unused_ras = bus.link ^ bus.ret;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= BOOT;
      pc_q          <= RESET_VECTOR;
      fetch_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      misalign_q <= misaligned;
      case (state)
        BOOT: begin
          pc_q          <= next_pc;
          state         <= RUN;
          fetch_valid_q <= 1'b1;
        end
        RUN: begin
          // A redirect always lands first; halt is honoured on a quiet cycle.
          if (bus.halt && !redirect) begin
            state         <= HALTED;
            fetch_valid_q <= 1'b0;
          end else begin
            pc_q <= next_pc;
          end
        end
        HALTED: begin
          pc_q <= next_pc;
          if (!bus.halt) begin
            state         <= RUN;
            fetch_valid_q <= 1'b1;
          end
        end
        default: begin
          state         <= BOOT;
          fetch_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.inst_address = pc_q;
  assign bus.pc_plus4     = pc_inc;
  assign bus.fetch_valid  = fetch_valid_q;
  assign bus.misalign_err = misalign_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus queues per-cycle expectations, a monitor checks them.
module tb_pc_sequencer;

  typedef struct {
    logic [31:0] addr;
    logic        fv;
    logic        me;
    string       nm;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  pc_sequencer_if #(.ADDR_W(32)) bus ();

  pc_sequencer #(
    .ADDR_W       (32),
    .RESET_VECTOR (32'h0000_0000),
    .EXC_VECTOR   (32'h0000_0080),
    .INST_BYTES   (4),
    .RAS_DEPTH    (4)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Queue the outputs expected after the coming rising edge, then move to the next falling edge.
  task automatic tick(input logic [31:0] a, input logic v, input logic m, input string nm);
    exp_t e;
    e.addr = a;
    e.fv   = v;
    e.me   = m;
    e.nm   = nm;
    exp_q.push_back(e);
    @(negedge clock);
  endtask

  task automatic clr();
    bus.exception    = 1'b0;
    bus.jr           = 1'b0;
    bus.branch_taken = 1'b0;
    bus.jump         = 1'b0;
    bus.link         = 1'b0;
    bus.ret          = 1'b0;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({e.nm, "_addr"}, bus.inst_address, e.addr);
        chk({e.nm, "_plus4"}, bus.pc_plus4, e.addr + 32'd4);
        chk({e.nm, "_valid"}, {31'd0, bus.fetch_valid}, {31'd0, e.fv});
        chk({e.nm, "_misalign"}, {31'd0, bus.misalign_err}, {31'd0, e.me});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] push_tgt [5] = '{32'h1000, 32'h1010, 32'h1020, 32'h1030, 32'h1040};
  logic [31:0] pop_exp  [5] = '{32'h1034, 32'h1024, 32'h1014, 32'h1004, 32'h2000};

  initial begin
    reset_n           = 1'b0;
    bus.halt          = 1'b0;
    bus.fetch_ready   = 1'b1;
    bus.jr_target     = '0;
    bus.branch_target = '0;
    bus.jump_target   = '0;
    clr();
    repeat (2) @(negedge clock);
    chk("reset_addr", bus.inst_address, 32'h0);
    chk("reset_valid", {31'd0, bus.fetch_valid}, 32'd0);
    chk("reset_misalign", {31'd0, bus.misalign_err}, 32'd0);
    reset_n = 1'b1;

    tick(32'h00, 1'b1, 1'b0, "boot");
    tick(32'h04, 1'b1, 1'b0, "seq4");
    tick(32'h08, 1'b1, 1'b0, "seq8");
    tick(32'h0C, 1'b1, 1'b0, "seqC");
    tick(32'h10, 1'b1, 1'b0, "seq10");

    bus.fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick(32'h10, 1'b1, 1'b0, "stall");
    bus.fetch_ready = 1'b1;
    tick(32'h14, 1'b1, 1'b0, "stall_release");

    bus.branch_taken = 1'b1; bus.branch_target = 32'h40;
    bus.jump = 1'b1;         bus.jump_target   = 32'h80;
    tick(32'h40, 1'b1, 1'b0, "br_over_j");
    bus.exception = 1'b1;
    tick(32'h80, 1'b1, 1'b0, "exc_over_all");
    clr();
    tick(32'h84, 1'b1, 1'b0, "after_exc");

    bus.jr = 1'b1; bus.jr_target = 32'h42;
    tick(32'h80, 1'b1, 1'b1, "misalign_jr");
    clr();
    tick(32'h84, 1'b1, 1'b0, "misalign_end");

    bus.fetch_ready = 1'b0; bus.jr = 1'b1; bus.jr_target = 32'h20;
    tick(32'h20, 1'b1, 1'b0, "redirect_in_stall");
    clr(); bus.fetch_ready = 1'b1;

    bus.halt = 1'b1;
    tick(32'h20, 1'b0, 1'b0, "halt");
    tick(32'h20, 1'b0, 1'b0, "halted_hold");
    bus.halt = 1'b0;
    tick(32'h20, 1'b1, 1'b0, "resume");
    tick(32'h24, 1'b1, 1'b0, "resume_seq");

    bus.halt = 1'b1;
    tick(32'h24, 1'b0, 1'b0, "halt2");
    bus.jump = 1'b1; bus.jump_target = 32'h300;
    tick(32'h300, 1'b0, 1'b0, "halted_redirect");
    clr(); bus.halt = 1'b0;
    tick(32'h300, 1'b1, 1'b0, "resume2");
    tick(32'h304, 1'b1, 1'b0, "resume2_seq");

    bus.halt = 1'b1; bus.branch_taken = 1'b1; bus.branch_target = 32'h500;
    tick(32'h500, 1'b1, 1'b0, "halt_with_redirect");
    clr();
    tick(32'h500, 1'b0, 1'b0, "halt_late");
    bus.halt = 1'b0;
    tick(32'h500, 1'b1, 1'b0, "resume3");
    tick(32'h504, 1'b1, 1'b0, "resume3_seq");

    bus.jump = 1'b1; bus.jump_target = 32'hFFFF_FFFC;
    tick(32'hFFFF_FFFC, 1'b1, 1'b0, "jump_top");
    clr();
    tick(32'h0, 1'b1, 1'b0, "wrap");
    tick(32'h4, 1'b1, 1'b0, "wrap_seq");

    bus.jr = 1'b1; bus.ret = 1'b1; bus.jr_target = 32'h600;
    tick(32'h600, 1'b1, 1'b0, "ret_empty");
    clr();
    tick(32'h604, 1'b1, 1'b0, "ret_empty_seq");

    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_addr", bus.inst_address, 32'h0);
    chk("async_reset_valid", {31'd0, bus.fetch_valid}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    tick(32'h0, 1'b1, 1'b0, "post_reset");

`ifdef PC_RAS_EN
    bus.jump = 1'b1; bus.jump_target = 32'h100;
    tick(32'h100, 1'b1, 1'b0, "ras_goto");
    bus.link = 1'b1; bus.jump_target = 32'h200;
    tick(32'h200, 1'b1, 1'b0, "ras_call");
    clr(); bus.jr = 1'b1; bus.ret = 1'b1; bus.jr_target = 32'h999C;
    tick(32'h104, 1'b1, 1'b0, "ras_return");
    clr();
    for (int i = 0; i < 5; i++) begin
      bus.jump = 1'b1; bus.link = 1'b1; bus.jump_target = push_tgt[i];
      tick(push_tgt[i], 1'b1, 1'b0, "ras_push");
    end
    clr();
    for (int i = 0; i < 5; i++) begin
      bus.jr = 1'b1; bus.ret = 1'b1; bus.jr_target = 32'h2000;
      tick(pop_exp[i], 1'b1, 1'b0, "ras_pop");
    end
    clr();
`endif

    @(negedge clock);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
